// File: rtl/cache_req_responder_pkg.sv
// Shared types and constants for the cache request responder.
package cache_resp_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [15:0] UNINIT_TAG = 16'hDEAD;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_WAIT,
        RS_RESP
    } resp_state_e;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/cache_req_responder_if.sv
// Cache request/response handshake bundle; master drives requests, slave answers.
interface cache_req_responder_if;
    import cache_resp_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              resp_stall;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  resp_stall, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output resp_stall, resp_valid, resp_rdata
    );

endinterface

// File: rtl/cache_req_responder_mem.sv
// Word array with byte-strobe writes and a per-word written flag (async clear).
// Read port is combinational; the caller registers the result.
module resp_word_mem
    import cache_resp_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              written
);

    logic [DATA_W-1:0]      mem [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] written_q;

    // Data array is deliberately not reset; only the flags are.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wstrb[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
        end else if (we && (|wstrb)) begin
            written_q[idx] <= 1'b1;
        end
    end

    assign rdata   = mem[idx];
    assign written = written_q[idx];

endmodule

// File: rtl/cache_req_responder.sv
// Fixed-latency, single-outstanding memory responder with saturating counters.
// Optional random stall injection in IDLE: define CACHE_RESP_RAND_STALL_EN.
module cache_req_responder
    import cache_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LAT         = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_req_responder_if.slave bus,
    output logic [CNT_W-1:0]     rd_count,
    output logic [CNT_W-1:0]     wr_count
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    resp_state_e       state_q;
    logic [CW-1:0]     wait_cnt_q;
    logic              stall_q;
    logic              valid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] hold_q;

    logic              accept;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_written;
    logic [DATA_W-1:0] rd_data_c;
    logic              rand_stall_n;
    logic              unused_addr_bits;

    assign accept           = bus.req_valid && !stall_q;
    assign idx              = bus.req_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.req_addr[ADDR_W-1:AW+2], bus.req_addr[1:0]};

    resp_word_mem #(.DEPTH_WORDS(DEPTH_WORDS)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept && bus.req_we),
        .wstrb   (bus.req_wstrb),
        .idx     (idx),
        .wdata   (bus.req_wdata),
        .rdata   (mem_rdata),
        .written (mem_written)
    );

    // Response payload as seen at the accept edge
    assign rd_data_c = bus.req_we    ? '0 :
                       mem_written   ? mem_rdata :
                                       {UNINIT_TAG, 16'(idx)};

`ifdef CACHE_RESP_RAND_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_n;

    assign lfsr_n = lfsr_step(lfsr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_n;
        end
    end

    // Registered stall tracks the LFSR value of the cycle it applies to
    assign rand_stall_n = (lfsr_n[1:0] == 2'b00);
`else
    assign rand_stall_n = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RS_IDLE;
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            hold_q     <= '0;
            rd_count   <= '0;
            wr_count   <= '0;
        end else begin
            valid_q <= 1'b0;
            rdata_q <= '0;
            stall_q <= rand_stall_n;
            case (state_q)
                RS_IDLE: begin
                    if (accept) begin
                        hold_q  <= rd_data_c;
                        stall_q <= 1'b1;
                        if (LAT == 1) begin
                            state_q <= RS_RESP;
                            valid_q <= 1'b1;
                            rdata_q <= rd_data_c;
                        end else begin
                            state_q    <= RS_WAIT;
                            wait_cnt_q <= CW'(LAT - 1);
                        end
                    end
                end
                RS_WAIT: begin
                    stall_q    <= 1'b1;
                    wait_cnt_q <= wait_cnt_q - CW'(1);
                    if (wait_cnt_q == CW'(1)) begin
                        state_q <= RS_RESP;
                        valid_q <= 1'b1;
                        rdata_q <= hold_q;
                    end
                end
                RS_RESP: state_q <= RS_IDLE;
                default: state_q <= RS_IDLE;
            endcase

            // Saturating statistics
            if (accept) begin
                if (bus.req_we) begin
                    if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
                end else begin
                    if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.resp_stall = stall_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;

endmodule

// File: doc/cache_req_responder.md
Name: cache_req_responder

Overview:
- Responder end of the cache request/response interface: consumes req_valid/req_we/req_addr/req_wdata/req_wstrb and produces resp_stall/resp_valid/resp_rdata.
- Word-addressed backing memory with byte strobes, fixed response latency and one request in flight.
- Used as the memory model behind the traffic generator in standalone bench runs, and as the refill/backing-store model behind the L1.
- Includes saturating read/write statistics counters for bench checks.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
- LAT, 2, cycles from request accept edge to the resp_valid cycle; at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  1  request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables; bit i covers byte i
- resp_stall  out  1  request not accepted this cycle
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data; 0 when not a read response
- rd_count  out  16  accepted reads, saturating
- wr_count  out  16  accepted writes, saturating

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, resp_stall=0, resp_valid=0, resp_rdata=0, rd_count=0, wr_count=0, all per-word written bits cleared. Memory array contents are not reset.
- Accept condition: req_valid && !resp_stall, sampled at the rising edge.
- Index: idx = req_addr[$clog2(DEPTH_WORDS)+1:2]. Higher address bits alias (wrap modulo DEPTH_WORDS).
- FSM IDLE (resp_stall=0): on accept, go to WAIT with wait_cnt=LAT-1; if LAT==1, go directly to RESP.
- FSM WAIT (resp_stall=1): decrement wait_cnt; when wait_cnt==1 at the edge, go to RESP.
- FSM RESP (resp_stall=1): resp_valid=1 for exactly one cycle, then IDLE. The earliest next accept is in the cycle after RESP.
- Latency: accept at edge N gives resp_valid high in the cycle following edge N+LAT-1, i.e. exactly LAT cycles after the accept cycle.
- Write: bytes with wstrb[i]=1 are committed at the accept edge and the word's written bit is set. wstrb=0 changes nothing and does not set the written bit, but still produces a response and counts as a write. Write response carries resp_rdata=0.
- Read: data is captured at the accept edge into a response register, so a read always sees every earlier accepted write. A never-written word returns {16'hDEAD, idx[15:0]} (idx zero-extended). wstrb is ignored on reads.
- resp_rdata is driven 0 in every cycle where resp_valid=0.
- Counters: each increments on accept by type and saturates at 16'hFFFF with no wrap.
- req_valid asserted in WAIT or RESP is ignored (stalled); nothing is latched.
- req_* values are don't-care while req_valid=0.
- Reset asserted mid-operation: immediate return to reset values. The in-flight response is dropped and never issued. A write already committed stays in the array but its written bit is cleared, so later reads return the DEAD pattern.

Optional Feature:
- Macro: CACHE_RESP_RAND_STALL_EN.
- When defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle. In IDLE, resp_stall = (lfsr[1:0]==2'b00), giving about 25% random stall injection. The LFSR resets to the seed.
- When undefined: no LFSR logic; resp_stall is 0 in IDLE.
- WAIT/RESP behaviour is identical in both builds.

Decomposition:
- Package cache_resp_pkg:
  - state enum resp_state_e {RS_IDLE, RS_WAIT, RS_RESP}
  - UNINIT_TAG = 16'hDEAD
  - LFSR_SEED = 16'hACE1
  - CNT_W = 16
- Sub-module resp_word_mem: DEPTH_WORDS x 32 array with per-byte write enable and a written-bit vector with asynchronous clear. Read port is combinational; the parent registers the read result.

Test Plan:
- Write 0x0000_1000 with 0xA5A5_0000, wstrb F; then read 0x0000_1000 -> resp_valid exactly 2 cycles after read accept, resp_rdata=0xA5A5_0000; wr_count=1, rd_count=1.
- Write 0x1010 with 0x1122_3344 (wstrb F), then write 0x1010 with 0xAABB_CCDD (wstrb 4'b0101); read 0x1010 -> 0x11BB_33DD.
- Read unwritten 0x0000_1040 (DEPTH 1024, idx 0x010) -> 0xDEAD_0010. Write 0x0000_0004 with 0x5555_AAAA, then read 0x0000_1004 -> 0x5555_AAAA (alias).
- Hold req_valid=1 continuously with LAT=2 -> resp_stall=1 during WAIT and RESP; exactly one response per accept; accepts spaced 3 cycles apart; no duplicate responses.
- Assert rst_n=0 during WAIT after a read accept -> no resp_valid thereafter; outputs at reset values; rd_count=0.
- With CACHE_RESP_RAND_STALL_EN defined and 200 back-to-back requests -> stall cycles observed in IDLE; every accepted request answered once; counters match the accepted totals.
